// File: rtl/fadd16_resp_queue.sv
// Issue/completion wrapper around the fixed-latency fadd16 pipeline. Ops are admitted on credit,
// tracked through the pipe, and their results are queued in accept order behind a valid/ready port.
module fadd16_resp_queue #(
  parameter int LATENCY  = 2,
  parameter int DEPTH    = 4,
  parameter int RES_W    = 16,
  parameter int FFLAGS_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_valid_i,
  output logic                       start_ready_o,
  output logic                       s0_vld_o,
  input  logic [RES_W-1:0]           fadd_res_i,
  input  logic [FFLAGS_W-1:0]        fadd_fflags_i,
  output logic                       finish_valid_o,
  input  logic                       finish_ready_i,
  output logic [RES_W-1:0]           res_o,
  output logic [FFLAGS_W-1:0]        fflags_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = RES_W + FFLAGS_W;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CRED_LIM  = (CNT_W+1)'(DEPTH);

  logic [LATENCY-1:0] vld_reg;
  logic [LATENCY-1:0] vld_next;
  logic [CNT_W-1:0]   inflight_cnt;
  logic [CNT_W:0]     occ_sum;

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [CNT_W-1:0]   fifo_cnt_reg;
  logic [CNT_W-1:0]   fifo_cnt_next;
  logic [ENTRY_W-1:0] head_entry;

  logic accept;
  logic push;
  logic pop;

  // Credit is derived from registered state only, so finish_ready_i never reaches start_ready_o.
  assign occ_sum       = {1'b0, fifo_cnt_reg} + {1'b0, inflight_cnt};
  assign start_ready_o = (occ_sum < CRED_LIM);
  assign occupancy_o   = occ_sum[CNT_W-1:0];
  assign accept        = start_valid_i & start_ready_o;
  assign s0_vld_o      = accept;

  // ---------------------------------------------------------------- in-flight tracker
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_track
    if (gi == 0) begin : g_head
      assign vld_next[gi] = accept;
    end else begin : g_shift
      assign vld_next[gi] = vld_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= vld_next;
    end
  end

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(vld_reg[i]);
    end
  end

  assign push = vld_reg[LATENCY-1];

  // ---------------------------------------------------------------- result FIFO
  assign finish_valid_o = (fifo_cnt_reg != '0);
  assign pop            = finish_valid_o & finish_ready_i;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_W'(1);
      2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_W'(1);
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fifo_cnt_reg <= fifo_cnt_next;
    end
  end

  // Storage is cleared on reset so the head reads as zero while the queue is empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      assert (fifo_cnt_reg != CNT_FULL);
      mem_reg[wr_ptr_reg] <= {fadd_fflags_i, fadd_res_i};
    end
  end

  assign head_entry = mem_reg[rd_ptr_reg];
  assign res_o      = head_entry[RES_W-1:0];
  assign fflags_o   = head_entry[ENTRY_W-1:RES_W];

endmodule

// File: tb/tb_fadd16_resp_queue.sv
// Bench for fadd16_resp_queue: plays the fadd16 pipe and compares every cycle against a
// queue-based model of ops in flight and results waiting in accept order.
`timescale 1ns/1ps
module tb_fadd16_resp_queue;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid_i;
  logic        start_ready_o;
  logic        s0_vld_o;
  logic [15:0] fadd_res_i;
  logic [4:0]  fadd_fflags_i;
  logic        finish_valid_o;
  logic        finish_ready_i;
  logic [15:0] res_o;
  logic [4:0]  fflags_o;
  logic [2:0]  occupancy_o;

  fadd16_resp_queue #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .RES_W   (16),
    .FFLAGS_W(5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_valid_i (start_valid_i),
    .start_ready_o (start_ready_o),
    .s0_vld_o      (s0_vld_o),
    .fadd_res_i    (fadd_res_i),
    .fadd_fflags_i (fadd_fflags_i),
    .finish_valid_o(finish_valid_o),
    .finish_ready_i(finish_ready_i),
    .res_o         (res_o),
    .fflags_o      (fflags_o),
    .occupancy_o   (occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] res;
    logic [4:0]  ff;
  } op_t;

  op_t infl_q[$];
  op_t fifo_q[$];

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int n_acc      = 0;
  int n_dut_acc  = 0;
  int n_dut_pop  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, compare outputs to the model, then advance.
  task automatic cycle(input bit sv, input bit fr, input logic [15:0] rv, input logic [4:0] fv);
    op_t op;
    op_t tmp;
    bit  exp_ready;
    bit  exp_fv;
    bit  acc;
    bit  pop;
    bit  due_now;
    int  occ;
    start_valid_i  = sv;
    finish_ready_i = fr;
    due_now = (infl_q.size() > 0) && (infl_q[0].due == cyc);
    if (due_now) begin
      fadd_res_i    = infl_q[0].res;
      fadd_fflags_i = infl_q[0].ff;
    end else begin
      fadd_res_i    = 16'($urandom);
      fadd_fflags_i = 5'($urandom);
    end
    #1;
    occ       = infl_q.size() + fifo_q.size();
    exp_ready = (occ < DEPTH);
    exp_fv    = (fifo_q.size() > 0);
    chk("start_ready", 32'(start_ready_o), 32'(exp_ready));
    chk("s0_vld", 32'(s0_vld_o), 32'(sv & exp_ready));
    chk("finish_valid", 32'(finish_valid_o), 32'(exp_fv));
    chk("occupancy", 32'(occupancy_o), 32'(occ));
    if (exp_fv) begin
      chk("res", 32'(res_o), 32'(fifo_q[0].res));
      chk("fflags", 32'(fflags_o), 32'(fifo_q[0].ff));
    end
    if (start_valid_i && start_ready_o) n_dut_acc++;
    if (finish_valid_o && finish_ready_i) n_dut_pop++;
    acc = sv & exp_ready;
    pop = fr & exp_fv;
    if (pop) tmp = fifo_q.pop_front();
    if (due_now) begin
      tmp = infl_q.pop_front();
      fifo_q.push_back(tmp);
    end
    if (acc) begin
      op.due = cyc + LATENCY;
      op.res = rv;
      op.ff  = fv;
      infl_q.push_back(op);
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int base_acc;
    int base_pop;
    int budget;
    rst_n          = 1'b0;
    start_valid_i  = 1'b0;
    finish_ready_i = 1'b0;
    fadd_res_i     = '0;
    fadd_fflags_i  = '0;

    // 1: reset
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ready", 32'(start_ready_o), 32'd1);
    chk("rst_fvalid", 32'(finish_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(start_ready_o), 32'd1);
    chk("post_rst_fvalid", 32'(finish_valid_o), 32'd0);
    chk("post_rst_res", 32'(res_o), 32'd0);
    chk("post_rst_occ", 32'(occupancy_o), 32'd0);
    @(negedge clk);

    // 2: single op, visible LATENCY+1 cycles after accept
    cycle(1'b1, 1'b0, 16'h3C00, 5'h01);
    cycle(1'b0, 1'b0, 16'h0, 5'h0);
    chk("single_not_yet", 32'(finish_valid_o), 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 5'h0);
    chk("single_valid", 32'(finish_valid_o), 32'd1);
    chk("single_res", 32'(res_o), 32'h3C00);
    chk("single_ff", 32'(fflags_o), 32'h01);
    cycle(1'b0, 1'b1, 16'h0, 5'h0);

    // 3: full-rate stream of 8
    base_acc = n_dut_acc;
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 16'(i), 5'(i));
    chk("stream_accepts", 32'(n_dut_acc - base_acc), 32'd8);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 16'h0, 5'h0);

    // 4: backpressure fills exactly DEPTH credits
    base_acc = n_dut_acc;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'($urandom), 5'($urandom));
    chk("bp_accepts", 32'(n_dut_acc - base_acc), 32'd4);
    chk("bp_ready", 32'(start_ready_o), 32'd0);
    chk("bp_occ", 32'(occupancy_o), 32'd4);
    cycle(1'b0, 1'b1, 16'h0, 5'h0);
    chk("bp_credit_back", 32'(start_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0, 5'h0);
    chk("bp_drained", 32'(finish_valid_o), 32'd0);

    // 5: reset with 2 in flight and 1 queued
    cycle(1'b1, 1'b0, 16'hAAAA, 5'h0A);
    cycle(1'b0, 1'b0, 16'h0, 5'h0);
    cycle(1'b1, 1'b0, 16'hBBBB, 5'h0B);
    cycle(1'b1, 1'b0, 16'hCCCC, 5'h0C);
    chk("pre_rst_occ", 32'(occupancy_o), 32'd3);
    chk("pre_rst_fvalid", 32'(finish_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_fvalid", 32'(finish_valid_o), 32'd0);
    chk("async_rst_occ", 32'(occupancy_o), 32'd0);
    chk("async_rst_res", 32'(res_o), 32'd0);
    infl_q.delete();
    fifo_q.delete();
    start_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'h0, 5'h0);
    chk("no_stale", 32'(finish_valid_o), 32'd0);

    // 6: random traffic, 1000 ops
    base_acc = n_dut_acc;
    base_pop = n_dut_pop;
    budget   = 0;
    while ((n_dut_acc - base_acc) < 1000 && budget < 20000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 5'($urandom));
      budget++;
    end
    chk("rand_accepts", 32'(n_dut_acc - base_acc), 32'd1000);
    budget = 0;
    while ((infl_q.size() + fifo_q.size()) > 0 && budget < 100) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 16'h0, 5'h0);
      budget++;
    end
    cycle(1'b0, 1'b1, 16'h0, 5'h0);
    chk("rand_pops", 32'(n_dut_pop - base_pop), 32'(n_dut_acc - base_acc));
    chk("rand_empty", 32'(finish_valid_o), 32'd0);
    chk("rand_occ", 32'(occupancy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
